// File: rtl/cont_anel_ctrl_if.sv
// Bus between the ring/shift counter sequencer and its job requester / datapath.
// The slave side is the sequencer; the master side drives jobs and returns the counter state.
interface cont_anel_ctrl_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
);
    logic             start;
    logic             abort;
    logic [1:0]       mode;
    logic [WIDTH-1:0] seed;
    logic [CNT_W-1:0] steps;
    logic [WIDTH-1:0] a;
    logic             sel;
    logic [WIDTH-1:0] i;
    logic             busy;
    logic             done;
    logic             mode_err;

    modport master (
        output start, abort, mode, seed, steps, a,
        input  sel, i, busy, done, mode_err
    );

    modport slave (
        input  start, abort, mode, seed, steps, a,
        output sel, i, busy, done, mode_err
    );
endinterface

// File: rtl/cont_anel_ctrl.sv
// Job sequencer for a 4-bit ring/shift counter: loads a seed, then steps it
// (shift, rotate right or rotate left) a programmed number of times.
module cont_anel_ctrl #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic               i_ck,
    input  logic               i_clr,
    cont_anel_ctrl_if.slave    bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [1:0]       r_mode;
    logic [WIDTH-1:0] r_seed;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic             r_done;
    logic             r_mode_err;
    logic             w_sel;
    logic [WIDTH-1:0] w_i;
    logic             w_accept;

    assign w_accept = (r_state == S_IDLE) && bus.start;

    always_ff @(posedge i_ck or negedge i_clr) begin
        if (!i_clr) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Job parameters and status flags; done trails the DONE state by one cycle.
    always_ff @(posedge i_ck or negedge i_clr) begin
        if (!i_clr) begin
            r_mode     <= '0;
            r_seed     <= '0;
            r_cnt      <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_mode_err <= 1'b0;
        end else begin
            r_busy <= (w_state_next == S_LOAD) || (w_state_next == S_RUN);
            r_done <= (r_state == S_DONE);
            if (w_accept) begin
                r_mode     <= bus.mode;
                r_seed     <= bus.seed;
                r_cnt      <= bus.steps;
                r_mode_err <= (bus.mode == 2'b11);
            end else if (r_state == S_RUN) begin
                r_cnt <= r_cnt - 1'b1;
                if (r_mode == 2'b11) begin
                    r_mode_err <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_sel        = 1'b1;
        w_i          = bus.a;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_state_next = S_LOAD;
                end
            end
            S_LOAD: begin
                w_i = r_seed;
                if (bus.abort) begin
                    w_state_next = S_IDLE;
                end else if (r_cnt == '0) begin
                    w_state_next = S_DONE;
                end else begin
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                // Mode 00 uses the datapath's own zero-fill shift; rotations go through the load path.
                case (r_mode)
                    2'b00: begin
                        w_sel = 1'b0;
                        w_i   = '0;
                    end
                    2'b01:   w_i = {bus.a[0], bus.a[WIDTH-1:1]};
                    2'b10:   w_i = {bus.a[WIDTH-2:0], bus.a[WIDTH-1]};
                    default: w_i = bus.a;
                endcase
                if (bus.abort) begin
                    w_state_next = S_IDLE;
                end else if (r_cnt == CNT_W'(1)) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign bus.sel      = w_sel;
    assign bus.i        = w_i;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.mode_err = r_mode_err;
endmodule

// File: tb/tb_cont_anel_ctrl.sv
// Bench for cont_anel_ctrl: a job-level model predicts the counter trajectory and
// status flags per cycle after each start edge; a negedge process compares every cycle.
module tb_cont_anel_ctrl;
    logic ck;
    logic clr;
    logic [3:0] dp_reg;
    logic       force_en;
    logic [3:0] force_val;

    cont_anel_ctrl_if #(.WIDTH(4), .CNT_W(8)) bus ();

    cont_anel_ctrl #(.WIDTH(4), .CNT_W(8)) dut (
        .i_ck  (ck),
        .i_clr (clr),
        .bus   (bus)
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    // Datapath: mux2p1 + FF_D per bit, reset by the same clear.
    always_ff @(posedge ck or negedge clr) begin
        if (!clr) dp_reg <= 4'h0;
        else      dp_reg <= bus.sel ? bus.i : {1'b0, dp_reg[3:1]};
    end
    assign bus.a = force_en ? force_val : dp_reg;

    int n_vec = 0;
    int n_err = 0;
    logic [3:0] exp_a;
    bit exp_busy, exp_done, exp_err, exp_idle, chk_en;
    int cur_k;
    int done_seen_k;

    function automatic void check(input string nm, input int act, input int req);
        n_vec++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d (t=%0t k=%0d)", nm, act, req, $time, cur_k);
        end
    endfunction

    // One step of the counter, by arithmetic on the 4-bit value.
    function automatic logic [3:0] step1(input logic [3:0] x, input logic [1:0] md);
        int v;
        v = int'(x);
        case (md)
            2'd0:    v = v / 2;
            2'd1:    v = (v % 2) * 8 + v / 2;
            2'd2:    v = (v * 2) % 16 + v / 8;
            default: v = v;
        endcase
        return 4'(v);
    endfunction

    function automatic logic [3:0] stepn(input logic [3:0] x, input logic [1:0] md, input int n);
        logic [3:0] y;
        y = x;
        for (int j = 0; j < n; j++) y = step1(y, md);
        return y;
    endfunction

    always @(negedge ck) begin
        if (chk_en) begin
            check("a", int'(bus.a), int'(exp_a));
            check("busy", int'(bus.busy), int'(exp_busy));
            check("done", int'(bus.done), int'(exp_done));
            check("mode_err", int'(bus.mode_err), int'(exp_err));
            if (exp_idle) begin
                check("idle_sel", int'(bus.sel), 1);
                check("idle_i", int'(bus.i), int'(exp_a));
            end
            if (bus.done) done_seen_k = cur_k;
        end
    end

    // Called at posedge+1: asserts clear mid-cycle, checks its immediate effect, releases it.
    task automatic do_reset(input bit frc, input logic [3:0] val);
        #2;
        clr       = 1'b0;
        force_en  = frc;
        force_val = val;
        exp_a     = frc ? val : 4'h0;
        exp_busy  = 1'b0;
        exp_done  = 1'b0;
        exp_err   = 1'b0;
        exp_idle  = 1'b1;
        cur_k     = -1;
        chk_en    = 1'b1;
        #1;
        check("rst_busy", int'(bus.busy), 0);
        check("rst_done", int'(bus.done), 0);
        check("rst_mode_err", int'(bus.mode_err), 0);
        check("rst_sel", int'(bus.sel), 1);
        check("rst_i", int'(bus.i), int'(frc ? val : 4'h0));
        repeat (2) @(posedge ck);
        #1;
        clr      = 1'b1;
        force_en = 1'b0;
        exp_a    = 4'h0;
    endtask

    // lit_a: literal final counter value (-1 skip); lit_dk: literal done edge (-1 none, -2 skip).
    task automatic run_job(input logic [3:0] s, input logic [1:0] md, input int n, input int ab,
                           input bit noise, input int lit_a, input int lit_dk, input int rst_k);
        int nst, idle_after, done_k, kmax;
        logic [3:0] prev;
        nst        = (ab >= 0) ? ab : n;
        idle_after = (ab >= 0) ? ab : n + 1;
        done_k     = (ab >= 0) ? -1 : n + 2;
        kmax       = idle_after + 3;
        prev       = exp_a;
        done_seen_k = -1;
        bus.start = 1'b1;
        bus.mode  = md;
        bus.seed  = s;
        bus.steps = 8'(n);
        bus.abort = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        for (int k = 0; k <= kmax; k++) begin
            @(posedge ck);
            #1;
            cur_k    = k;
            exp_a    = (k == 0) ? prev : stepn(s, md, (k - 1 < nst) ? k - 1 : nst);
            exp_busy = (k <= nst);
            exp_done = (k == done_k);
            if (k == 0) exp_err = (md == 2'b11);
            exp_idle = (k > idle_after);
            bus.start = noise && !exp_idle && ($urandom_range(0, 2) == 0);
            if (noise) begin
                bus.mode  = 2'($urandom);
                bus.seed  = 4'($urandom);
                bus.steps = 8'($urandom);
            end
            bus.abort = (k == ab) ||
                        (noise && (k > idle_after || (ab < 0 && k == n + 1)) &&
                         ($urandom_range(0, 1) == 1));
            if (k == rst_k) begin
                bus.start = 1'b0;
                bus.abort = 1'b0;
                do_reset(1'b0, 4'h0);
                return;
            end
        end
        if (lit_a >= 0)  check("lit_final_a", int'(bus.a), lit_a);
        if (lit_dk > -2) check("lit_done_k", done_seen_k, lit_dk);
    endtask

    initial begin
        int n, ab;
        clr       = 1'b1;
        force_en  = 1'b0;
        force_val = 4'h0;
        chk_en    = 1'b0;
        exp_a     = 4'h0;
        cur_k     = -1;
        done_seen_k = -1;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.mode  = 2'b00;
        bus.seed  = 4'h0;
        bus.steps = 8'h0;
        @(posedge ck);
        #1;
        do_reset(1'b1, 4'b1010);

        run_job(4'b0001, 2'b01, 4, -1, 1'b0, 4'b0001, 6, -1);
        run_job(4'b1011, 2'b00, 3, -1, 1'b0, 4'b0001, 5, -1);
        run_job(4'b0110, 2'b10, 0, -1, 1'b0, 4'b0110, 2, -1);
        run_job(4'b0001, 2'b10, 5, 2, 1'b0, 4'b0100, -1, -1);
        run_job(4'b0101, 2'b11, 2, -1, 1'b1, 4'b0101, 4, -1);
        check("t6_err_sticky", int'(bus.mode_err), 1);
        run_job(4'b1111, 2'b00, 6, -1, 1'b0, 4'b0000, 8, -1);
        check("t6_err_cleared", int'(bus.mode_err), 0);
        run_job(4'b1001, 2'b01, 255, -1, 1'b0, 4'b0011, 257, -1);

        for (int j = 0; j < 40; j++) begin
            n  = int'($urandom_range(0, 10));
            ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, n)) : -1;
            run_job(4'($urandom), 2'($urandom), n, ab, 1'b1, -1, -2, (j == 20) ? n / 2 + 1 : -1);
        end

        @(posedge ck);
        #1;
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
